// File: rtl/rst_clk_seq.sv
// Reset stretcher and sleep/clock-gate sequencer feeding RstSync (rstn_i, clk_en).
// Optional drain timeout is enabled by defining RST_CLK_SEQ_TIMEOUT_EN.
module rst_clk_seq #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned DRAIN_CYCLES    = 255,
  parameter int unsigned WAKE_CYCLES     = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sw_rst_req_i,
  input  logic       sleep_req_i,
  input  logic       idle_i,
  output logic       rstn_o,
  output logic       clk_en_o,
  output logic       sleep_ack_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_RW  = (RST_HOLD_CYCLES > WAKE_CYCLES) ? RST_HOLD_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_RW > DRAIN_CYCLES) ? MAX_RW : DRAIN_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_GATED = 3'd3,
    S_WAKE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          restart;

`ifdef RST_CLK_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  logic timeout_q;
  logic timeout_set;
`endif

  always_comb begin
    state_d = state_q;
`ifdef RST_CLK_SEQ_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    unique case (state_q)
      S_RESET: if (cnt_q == HOLD_LAST) state_d = S_RUN;
      S_RUN:   if (sleep_req_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (idle_i)            state_d = S_GATED;
        else if (!sleep_req_i) state_d = S_RUN;
`ifdef RST_CLK_SEQ_TIMEOUT_EN
        else if (cnt_q == DRAIN_LAST) begin
          state_d     = S_GATED;
          timeout_set = 1'b1;
        end
`endif
      end
      S_GATED: if (!sleep_req_i) state_d = S_WAKE;
      S_WAKE:  if (cnt_q == WAKE_LAST) state_d = S_RUN;
      default: state_d = S_RESET;
    endcase
    if (sw_rst_req_i) begin
      state_d = S_RESET;
`ifdef RST_CLK_SEQ_TIMEOUT_EN
      timeout_set = 1'b0;
`endif
    end
  end

  // A software reset while already in RESET must restart the hold count.
  assign restart = sw_rst_req_i || (state_d != state_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      rstn_o      <= 1'b0;
      clk_en_o    <= 1'b1;
      sleep_ack_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= restart ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + CW'(1));
      // Outputs decode the next state so they are flop outputs aligned with state_o.
      rstn_o      <= (state_d != S_RESET);
      clk_en_o    <= (state_d != S_GATED);
      sleep_ack_o <= (state_d == S_GATED) || (state_d == S_WAKE);
    end
  end

`ifdef RST_CLK_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)           timeout_q <= 1'b0;
    else if (sw_rst_req_i) timeout_q <= 1'b0;
    else if (timeout_set)  timeout_q <= 1'b1;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign state_o = state_q;

endmodule
